relu_backward_mask: RTL and testbench
=====================================

Name: relu_backward_mask

Overview:
- Backward-pass counterpart of the pipelined ReLU stage.
- During the forward pass it records one mask bit per activation into a FIFO: 1 if the pre-activation is non-negative (the value passed through), 0 if negative (the value was zeroed).
- During the backward pass it pairs each incoming gradient with the oldest stored mask bit. It forwards the gradient unchanged if the bit is 1 and forwards zero if the bit is 0.
- Sits between the ReLU forward path and the upstream gradient path of the vector datapath; all three streams use valid/ready.

Parameters:
- DATA_W, 16, width of pre-activations and gradients (two's complement).
- DEPTH, 64, mask FIFO entries; must be a power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, derived localparam, width of the occupancy count.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stored masks and of the output stage.
- fwd_valid  in  1  forward pre-activation valid.
- fwd_ready  out  1  mask FIFO can accept a forward sample.
- fwd_data  in  DATA_W  forward pre-activation (ReLU input); only the sign bit is used.
- grad_in_valid  in  1  incoming gradient valid.
- grad_in_ready  out  1  gradient accepted this cycle.
- grad_in_data  in  DATA_W  incoming gradient.
- grad_out_valid  out  1  masked gradient valid.
- grad_out_ready  in  1  downstream accepts the masked gradient.
- grad_out_data  out  DATA_W  masked gradient.
- mask_count  out  CNT_W  number of stored, unconsumed mask bits.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers cleared, mask_count=0.
  - grad_out_valid=0, grad_out_data=0.
  - fwd_ready and grad_in_ready are 0 while rst is high.
- Mask rule:
  - mask = ~fwd_data[DATA_W-1].
  - Zero input gives mask 1, matching the forward stage, which passes zero through.
  - Magnitude bits are ignored.
- Push:
  - fwd_ready = !full && !flush && !rst.
  - On fwd_valid && fwd_ready, the mask is written at wr_ptr and wr_ptr increments (mod DEPTH).
  - The written bit is poppable from the next cycle.
- Pop / gradient accept:
  - grad_in_ready = !empty && !flush && !rst && (!grad_out_valid || grad_out_ready).
  - On acceptance, the head mask bit is read and rd_ptr increments.
  - On the same edge, the output register loads grad_out_data = mask ? grad_in_data : 0, and grad_out_valid is set to 1.
- Latency: exactly 1 cycle from gradient acceptance to grad_out_valid. Throughput is 1 per cycle with grad_out_ready held high.
- Output hold: while grad_out_valid && !grad_out_ready, grad_out_data and grad_out_valid are stable, and no gradient is accepted.
- Output drain: if grad_out_ready is high and no new gradient is accepted, grad_out_valid clears on the next edge; grad_out_data keeps its last value.
- Ordering: FIFO, so the Nth gradient is paired with the Nth forward sample after the last flush or reset.
- Occupancy:
  - mask_count is +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - full = (mask_count == DEPTH); empty = (mask_count == 0).
- Boundaries:
  - Full: fwd_ready=0 even if a pop occurs in the same cycle (no pass-through).
  - Empty: grad_in_ready=0 even if a push occurs in the same cycle (no bypass); a gradient with no mask stalls.
  - Pointer wrap: DEPTH-1 wraps to 0; occupancy is tracked by mask_count, not by pointer compare.
- Flush:
  - Dominates push and pop in its cycle.
  - Next edge: pointers=0, mask_count=0, grad_out_valid=0.
  - A pending output beat is discarded.
- Reset mid-stream: identical to flush, plus grad_out_data=0.

Decomposition:
- Package relu_pkg:
  - DATA_W default constant.
  - typedef act_t (logic signed [DATA_W-1:0]).
  - Function relu_mask(act_t) returning a 1-bit mask; shared with the forward stage's sign test.
- One sub-module, relu_mask_fifo:
  - 1-bit-wide, DEPTH-entry synchronous FIFO with push/pop/flush, full/empty, and count.
  - The top level adds the handshake logic and the output register.

Test Plan:
- Basic masking:
  - Stimulus: push fwd 0x0005, 0xFFFB, 0x0000, 0x8000; then gradients 0x0100, 0x0200, 0x0300, 0x0400 with grad_out_ready=1.
  - Required response: outputs 0x0100, 0x0000, 0x0300, 0x0000, each 1 cycle after acceptance; mask_count returns to 0.
- Full/empty:
  - Push 64 positive samples → fwd_ready=0, mask_count=64; a 65th push with a simultaneous pop is not accepted.
  - With the FIFO empty, grad_in_valid=1 → grad_in_ready=0 until a push lands, then accepted the following cycle.
- Backpressure:
  - Stimulus: streaming gradients with grad_out_ready low for 3 cycles mid-burst.
  - Required response: grad_out_data held stable, grad_in_ready=0 for those cycles, no beat lost or duplicated, order preserved.
- Wrap-around: interleave 200 pushes and pops at random rates with masks alternating 1/0 → output matches the reference model across multiple pointer wraps.
- Flush:
  - Stimulus: 10 masks stored and one output beat stalled; assert flush for 1 cycle.
  - Required response: mask_count=0 and grad_out_valid=0 next cycle; the next push/gradient pair behaves as the first after reset.
- Reset mid-operation: rst for 1 cycle during a burst → all outputs at reset values, ready signals low during rst; normal operation after release.

Source files
------------

// File: rtl/relu_pkg.sv
// -----------------------------------------------------------------------------
// relu_pkg
// Shared definitions for the ReLU forward stage and its backward-pass mask.
//   DEFAULT_DATA_W : default activation / gradient width (two's complement)
//   act_t          : signed activation type of the default width
//   relu_mask()    : 1 when the forward stage passes the value through
//                    (non-negative, including zero), 0 when it zeroes it
// -----------------------------------------------------------------------------
package relu_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef logic signed [DEFAULT_DATA_W-1:0] act_t;

    // Only the sign matters: zero passes through the forward stage, so it
    // must map to mask 1 here as well.
    function automatic logic relu_mask(input act_t act);
        return ~act[DEFAULT_DATA_W-1];
    endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// -----------------------------------------------------------------------------
// relu_mask_fifo
// 1-bit-wide synchronous FIFO holding one ReLU mask bit per forward sample.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears pointers and count)
//   flush      synchronous clear, same effect as rst on the control state
//   push       write push_mask at the tail (ignored when full)
//   push_mask  mask bit to store
//   pop        advance the head (ignored when empty)
//   pop_mask   mask bit at the head, valid whenever !empty
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored, unconsumed bits
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module relu_mask_fifo #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             push_mask,
    input  logic             pop,
    output logic             pop_mask,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_mask = mem[rd_ptr];

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // NOTE: storage has no reset; stale bits are never visible because the
    // count gates every read, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_mask;
        end
    end

    // Occupancy comes from count_q, not from comparing pointers, so equal
    // pointers are unambiguous (either empty or full).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/relu_backward_mask.sv
// -----------------------------------------------------------------------------
// relu_backward_mask
// Backward-pass partner of the ReLU stage. Forward samples leave one mask bit
// each in a FIFO; each incoming gradient is paired with the oldest bit and is
// forwarded unchanged (bit 1) or replaced by zero (bit 0).
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   flush                synchronous clear of stored masks and output stage
//   fwd_valid/ready/data forward pre-activation stream (sign bit used only)
//   grad_in_valid/ready/data  upstream gradient stream
//   grad_out_valid/ready/data masked gradient stream, registered output
//   mask_count           number of stored, unconsumed mask bits
// -----------------------------------------------------------------------------
module relu_backward_mask
    import relu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fwd_valid,
    output logic                  fwd_ready,
    input  logic [DATA_W-1:0]     fwd_data,
    input  logic                  grad_in_valid,
    output logic                  grad_in_ready,
    input  logic [DATA_W-1:0]     grad_in_data,
    output logic                  grad_out_valid,
    input  logic                  grad_out_ready,
    output logic [DATA_W-1:0]     grad_out_data,
    output logic [$clog2(DEPTH):0] mask_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic fwd_mask;
    logic head_mask;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // Reuse the forward stage's sign test whenever the widths line up.
    generate
        if (DATA_W == DEFAULT_DATA_W) begin : g_pkg_mask
            assign fwd_mask = relu_mask(act_t'(fwd_data));
        end else begin : g_sign_mask
            assign fwd_mask = ~fwd_data[DATA_W-1];
        end
    endgenerate

    // No pass-through when full and no bypass when empty: readiness depends
    // only on the registered occupancy, never on the other stream's handshake.
    assign fwd_ready     = !full && !flush && !rst;
    assign grad_in_ready = !empty && !flush && !rst
                           && (!grad_out_valid || grad_out_ready);

    assign push = fwd_valid && fwd_ready;
    assign pop  = grad_in_valid && grad_in_ready;

    relu_mask_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_mask (fwd_mask),
        .pop       (pop),
        .pop_mask  (head_mask),
        .full      (full),
        .empty     (empty),
        .count     (mask_count)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // Flush drops a pending beat but keeps the data; only rst zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            grad_out_valid <= 1'b0;
            grad_out_data  <= '0;
        end else if (flush) begin
            grad_out_valid <= 1'b0;
        end else if (pop) begin
            grad_out_valid <= 1'b1;
            grad_out_data  <= head_mask ? grad_in_data : '0;
        end else if (grad_out_ready) begin
            grad_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_backward_mask.sv
// -----------------------------------------------------------------------------
// tb_relu_backward_mask
// Scoreboard bench: the stimulus side pushes the expected masked gradient at
// the moment a gradient is accepted; a monitor pops and compares whenever an
// output beat is transferred. Directed vectors carry hand-computed results.
// -----------------------------------------------------------------------------
module tb_relu_backward_mask;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              fwd_valid;
    logic              fwd_ready;
    logic [DATA_W-1:0] fwd_data;
    logic              grad_in_valid;
    logic              grad_in_ready;
    logic [DATA_W-1:0] grad_in_data;
    logic              grad_out_valid;
    logic              grad_out_ready;
    logic [DATA_W-1:0] grad_out_data;
    logic [6:0]        mask_count;

    relu_backward_mask #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fwd_valid      (fwd_valid),
        .fwd_ready      (fwd_ready),
        .fwd_data       (fwd_data),
        .grad_in_valid  (grad_in_valid),
        .grad_in_ready  (grad_in_ready),
        .grad_in_data   (grad_in_data),
        .grad_out_valid (grad_out_valid),
        .grad_out_ready (grad_out_ready),
        .grad_out_data  (grad_out_data),
        .mask_count     (mask_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: behaviour of the block as seen at its ports.
    bit              mask_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] hand_q[$];
    int              model_cnt = 0;
    bit              model_ov  = 1'b0;
    bit              last_fwd_acc;
    bit              last_grad_acc;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // One clock: check readiness/occupancy at the negedge, advance the model
    // by what the block must accept at the coming edge, then move past it.
    task automatic step();
        bit exp_fr;
        bit exp_gr;
        bit m;
        logic [DATA_W-1:0] e;
        @(negedge clk);
        exp_fr = !rst && !flush && (model_cnt < DEPTH);
        exp_gr = !rst && !flush && (model_cnt > 0) && (!model_ov || grad_out_ready);
        check("fwd_ready", 32'(fwd_ready), 32'(exp_fr));
        check("grad_in_ready", 32'(grad_in_ready), 32'(exp_gr));
        check("mask_count", 32'(mask_count), 32'(model_cnt));
        check("grad_out_valid", 32'(grad_out_valid), 32'(model_ov));
        last_fwd_acc  = 1'b0;
        last_grad_acc = 1'b0;
        if (rst || flush) begin
            mask_q.delete();
            exp_q.delete();
            model_cnt = 0;
            model_ov  = 1'b0;
        end else begin
            last_fwd_acc  = fwd_valid && exp_fr;
            last_grad_acc = grad_in_valid && exp_gr;
            if (last_grad_acc) begin
                m = mask_q.pop_front();
                e = m ? grad_in_data : '0;
                if (hand_q.size() > 0) e = hand_q.pop_front();
                exp_q.push_back(e);
            end
            if (last_fwd_acc) mask_q.push_back(!fwd_data[DATA_W-1]);
            model_cnt = model_cnt + int'(last_fwd_acc) - int'(last_grad_acc);
            if (last_grad_acc)       model_ov = 1'b1;
            else if (grad_out_ready) model_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares transferred beats and checks stability under stall.
    bit                hold_pending = 1'b0;
    logic [DATA_W-1:0] hold_data;

    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (hold_pending) begin
                check("hold_valid", 32'(grad_out_valid), 32'd1);
                check("hold_data", 32'(grad_out_data), 32'(hold_data));
            end
            if (grad_out_valid && grad_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(grad_out_data), 32'hDEAD_BEEF);
                end else begin
                    check("grad_out_data", 32'(grad_out_data), 32'(exp_q.pop_front()));
                end
            end
        end
        hold_pending = grad_out_valid && !grad_out_ready && !rst && !flush;
        hold_data    = grad_out_data;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [DATA_W-1:0] basic_fwd  [4] = '{16'h0005, 16'hFFFB, 16'h0000, 16'h8000};
    logic [DATA_W-1:0] basic_grad [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    logic [DATA_W-1:0] basic_exp  [4] = '{16'h0100, 16'h0000, 16'h0300, 16'h0000};

    initial begin
        int k;
        int pushes;
        int pops;
        logic [DATA_W-1:0] gdata;

        rst = 1'b1; flush = 1'b0;
        fwd_valid = 1'b0; fwd_data = '0;
        grad_in_valid = 1'b0; grad_in_data = '0;
        grad_out_ready = 1'b1;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;
        check("reset_count", 32'(mask_count), 32'd0);
        check("reset_valid", 32'(grad_out_valid), 32'd0);
        check("reset_data", 32'(grad_out_data), 32'd0);

        // Basic masking with hand-computed results.
        for (int i = 0; i < 4; i++) begin
            fwd_valid = 1'b1; fwd_data = basic_fwd[i];
            step();
        end
        fwd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hand_q.push_back(basic_exp[i]);
            grad_in_valid = 1'b1; grad_in_data = basic_grad[i];
            step();
        end
        grad_in_valid = 1'b0;
        step(); step();
        check("basic_count_zero", 32'(mask_count), 32'd0);

        // Fill to DEPTH, then a push alongside a pop must be refused.
        fwd_valid = 1'b1; fwd_data = 16'h0001;
        repeat (DEPTH) step();
        check("full_count", 32'(mask_count), 32'(DEPTH));
        grad_in_valid = 1'b1; grad_in_data = 16'h0777;
        step();
        check("full_no_passthrough", 32'(mask_count), 32'(DEPTH - 1));
        fwd_valid = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            grad_in_data = 16'h2000 + 16'(i);
            step();
        end
        // Empty: gradient stalls; a push is not bypassed, accepted next cycle.
        grad_in_data = 16'h4321;
        repeat (3) step();
        fwd_valid = 1'b1; fwd_data = 16'h8001;
        step();
        check("empty_no_bypass", 32'(last_grad_acc), 32'd0);
        fwd_valid = 1'b0;
        step();
        check("empty_accept_next", 32'(last_grad_acc), 32'd1);
        grad_in_valid = 1'b0;
        step();

        // Backpressure mid-burst.
        for (int i = 0; i < 8; i++) begin
            fwd_valid = 1'b1;
            fwd_data  = (i % 2 == 0) ? 16'h0010 : 16'hFFF0;
            step();
        end
        fwd_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 8; c++) begin
            grad_out_ready = !(c >= 3 && c < 6);
            grad_in_valid  = 1'b1;
            grad_in_data   = 16'h1000 + 16'(k);
            step();
            if (last_grad_acc) k++;
        end
        check("bp_all_accepted", 32'(k), 32'd8);
        grad_in_valid = 1'b0; grad_out_ready = 1'b1;
        step(); step();

        // Random interleave across several pointer wraps.
        pushes = 0; pops = 0; gdata = 16'(($urandom));
        for (int c = 0; c < 3000 && (pushes < 200 || pops < 200); c++) begin
            fwd_valid      = (pushes < 200) && ($urandom_range(0, 3) != 0);
            fwd_data       = (pushes % 2 == 0) ? (16'($urandom) & 16'h7FFF)
                                               : (16'($urandom) | 16'h8000);
            grad_in_valid  = (pops < 200) && ($urandom_range(0, 3) != 0);
            grad_in_data   = gdata;
            grad_out_ready = ($urandom_range(0, 4) != 0);
            step();
            if (last_fwd_acc) pushes++;
            if (last_grad_acc) begin
                pops++;
                gdata = 16'($urandom);
            end
        end
        fwd_valid = 1'b0; grad_in_valid = 1'b0; grad_out_ready = 1'b1;
        repeat (3) step();
        check("wrap_pops", 32'(pops), 32'd200);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Flush with 10 masks stored and one beat stalled.
        fwd_valid = 1'b1; fwd_data = 16'h0002;
        repeat (11) step();
        fwd_valid = 1'b0;
        grad_out_ready = 1'b0;
        grad_in_valid = 1'b1; grad_in_data = 16'h0BAD;
        step();
        grad_in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", 32'(mask_count), 32'd0);
        check("flush_valid", 32'(grad_out_valid), 32'd0);
        grad_out_ready = 1'b1;
        hand_q.push_back(16'h0000);
        fwd_valid = 1'b1; fwd_data = 16'hFFFF;
        step();
        fwd_valid = 1'b0;
        grad_in_valid = 1'b1; grad_in_data = 16'h1234;
        step();
        grad_in_valid = 1'b0;
        step();

        // Reset in the middle of a burst.
        fwd_valid = 1'b1; fwd_data = 16'h0003;
        repeat (6) step();
        grad_in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            grad_in_data = 16'h5500 + 16'(i);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        fwd_valid = 1'b0; grad_in_valid = 1'b0;
        check("rst_mid_count", 32'(mask_count), 32'd0);
        check("rst_mid_valid", 32'(grad_out_valid), 32'd0);
        check("rst_mid_data", 32'(grad_out_data), 32'd0);
        hand_q.push_back(16'h0F0F);
        fwd_valid = 1'b1; fwd_data = 16'h7FFF;
        step();
        fwd_valid = 1'b0;
        grad_in_valid = 1'b1; grad_in_data = 16'h0F0F;
        step();
        grad_in_valid = 1'b0;
        step(); step();
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
